// File: rtl/pair_scheduler.sv
// Pairs products of the same row and issues them to a pipelined adder, folding
// adder results back in until each row reduces to a single value, then retires it.
module pair_scheduler #(
  parameter int ROW_WIDTH = 10,
  parameter int NUM_CTX   = 4,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_in,
  input  logic [ROW_WIDTH-1:0] row_in,
  input  logic [65:0]          v_in,
  input  logic                 last_in,
  output logic                 ready_out,
  input  logic                 fb_push,
  input  logic [ROW_WIDTH-1:0] fb_row,
  input  logic [65:0]          fb_v,
  output logic                 add_push,
  output logic [ROW_WIDTH-1:0] add_row,
  output logic [65:0]          add_v0,
  output logic [65:0]          add_v1,
  output logic                 done_push,
  output logic [ROW_WIDTH-1:0] done_row,
  output logic [65:0]          done_v
);

  localparam int IW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  // Handshake: a product transfers on a rising edge where push_in & ready_out;
  // fb_push is never back-pressured, add_push/done_push are single-cycle strobes.

  logic [NUM_CTX-1:0]   valid_q, valid_d;
  logic [NUM_CTX-1:0]   hold_valid_q, hold_valid_d;
  logic [NUM_CTX-1:0]   last_seen_q, last_seen_d;
  logic [ROW_WIDTH-1:0] row_q [NUM_CTX];
  logic [ROW_WIDTH-1:0] row_d [NUM_CTX];
  logic [65:0]          hold_v_q [NUM_CTX];
  logic [65:0]          hold_v_d [NUM_CTX];
  logic [CNT_WIDTH-1:0] inflight_q [NUM_CTX];
  logic [CNT_WIDTH-1:0] inflight_d [NUM_CTX];

  logic [NUM_CTX-1:0] p_match, f_match, pr_tgt, fb_tgt, complete;
  logic               p_hit, free_any, f_would, p_would, conflict, accept;
  logic [IW-1:0]      p_hit_idx, free_idx, p_idx, f_idx;

  logic                 iss;
  logic [ROW_WIDTH-1:0] iss_row;
  logic [65:0]          iss_v0, iss_v1;
  logic                 retire;
  logic [IW-1:0]        ret_idx;
  logic [ROW_WIDTH-1:0] ret_row;
  logic [65:0]          ret_v;

  // Context lookup, allocation and the single-issue arbitration.
  always_comb begin
    p_match   = '0;
    f_match   = '0;
    pr_tgt    = '0;
    fb_tgt    = '0;
    p_hit     = 1'b0;
    free_any  = 1'b0;
    p_hit_idx = '0;
    free_idx  = '0;
    f_idx     = '0;
    for (int i = NUM_CTX - 1; i >= 0; i--) begin
      p_match[i] = valid_q[i] && (row_q[i] == row_in);
      f_match[i] = valid_q[i] && (row_q[i] == fb_row);
      if (p_match[i]) begin
        p_hit     = 1'b1;
        p_hit_idx = IW'(i);
      end
      if (f_match[i]) f_idx = IW'(i);
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
    p_idx     = p_hit ? p_hit_idx : free_idx;
    f_would   = fb_push && hold_valid_q[f_idx];
    p_would   = push_in && p_hit && hold_valid_q[p_idx];
    conflict  = f_would && p_would && (p_idx != f_idx);
    ready_out = !rst && (p_hit || free_any) && !conflict;
    accept    = push_in && ready_out;
    for (int i = 0; i < NUM_CTX; i++) begin
      pr_tgt[i] = accept && (p_idx == IW'(i));
      fb_tgt[i] = fb_push && f_match[i];
    end
  end

  // Per-context update, issue selection and retirement.
  always_comb begin
    valid_d      = valid_q;
    hold_valid_d = hold_valid_q;
    last_seen_d  = last_seen_q;
    row_d        = row_q;
    hold_v_d     = hold_v_q;
    inflight_d   = inflight_q;
    iss          = 1'b0;
    iss_row      = '0;
    iss_v0       = '0;
    iss_v1       = '0;
    retire       = 1'b0;
    ret_idx      = '0;
    ret_row      = '0;
    ret_v        = '0;
    complete     = '0;

    for (int i = 0; i < NUM_CTX; i++) begin
      complete[i] = valid_q[i] && last_seen_q[i] && hold_valid_q[i] &&
                    (inflight_q[i] == '0) &&
                    !(push_in && p_match[i]) && !fb_tgt[i];
    end
    for (int i = NUM_CTX - 1; i >= 0; i--) begin
      if (complete[i]) begin
        retire  = 1'b1;
        ret_idx = IW'(i);
      end
    end

    for (int i = 0; i < NUM_CTX; i++) begin
      if (fb_tgt[i] && pr_tgt[i]) begin
        // One result returns and one pair leaves: inflight is unchanged.
        iss     = 1'b1;
        iss_row = row_q[i];
        if (hold_valid_q[i]) begin
          iss_v0      = hold_v_q[i];
          iss_v1      = fb_v;
          hold_v_d[i] = v_in;
        end else begin
          iss_v0 = fb_v;
          iss_v1 = v_in;
        end
      end else if (fb_tgt[i]) begin
        if (hold_valid_q[i]) begin
          iss             = 1'b1;
          iss_row         = row_q[i];
          iss_v0          = hold_v_q[i];
          iss_v1          = fb_v;
          hold_valid_d[i] = 1'b0;
        end else begin
          hold_valid_d[i] = 1'b1;
          hold_v_d[i]     = fb_v;
          inflight_d[i]   = inflight_q[i] - CNT_WIDTH'(1);
        end
      end else if (pr_tgt[i]) begin
        if (!p_hit) begin
          valid_d[i]      = 1'b1;
          row_d[i]        = row_in;
          hold_valid_d[i] = 1'b1;
          hold_v_d[i]     = v_in;
          inflight_d[i]   = '0;
          last_seen_d[i]  = 1'b0;
        end else if (hold_valid_q[i]) begin
          iss             = 1'b1;
          iss_row         = row_q[i];
          iss_v0          = hold_v_q[i];
          iss_v1          = v_in;
          hold_valid_d[i] = 1'b0;
          inflight_d[i]   = inflight_q[i] + CNT_WIDTH'(1);
        end else begin
          hold_valid_d[i] = 1'b1;
          hold_v_d[i]     = v_in;
        end
      end
      if (pr_tgt[i] && last_in) last_seen_d[i] = 1'b1;
    end

    // A retiring context has no traffic this cycle, so clearing it cannot race an update.
    if (retire) begin
      ret_row               = row_q[ret_idx];
      ret_v                 = hold_v_q[ret_idx];
      valid_d[ret_idx]      = 1'b0;
      hold_valid_d[ret_idx] = 1'b0;
      last_seen_d[ret_idx]  = 1'b0;
      inflight_d[ret_idx]   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      hold_valid_q <= '0;
      last_seen_q  <= '0;
      for (int i = 0; i < NUM_CTX; i++) begin
        row_q[i]      <= '0;
        hold_v_q[i]   <= '0;
        inflight_q[i] <= '0;
      end
      add_push  <= 1'b0;
      add_row   <= '0;
      add_v0    <= '0;
      add_v1    <= '0;
      done_push <= 1'b0;
      done_row  <= '0;
      done_v    <= '0;
    end else begin
      valid_q      <= valid_d;
      hold_valid_q <= hold_valid_d;
      last_seen_q  <= last_seen_d;
      row_q        <= row_d;
      hold_v_q     <= hold_v_d;
      inflight_q   <= inflight_d;
      add_push     <= iss;
      if (iss) begin
        add_row <= iss_row;
        add_v0  <= iss_v0;
        add_v1  <= iss_v1;
      end
      done_push <= retire;
      if (retire) begin
        done_row <= ret_row;
        done_v   <= ret_v;
      end
    end
  end

endmodule

// File: tb/tb_pair_scheduler.sv
// Bench for pair_scheduler: directed vector table, multi-cycle corner sequences,
// and random rows checked against per-row sums with a modular-add adder model.
module tb_pair_scheduler;
  localparam int RW = 10;
  localparam int NC = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_in = 1'b0;
  logic [RW-1:0] row_in = '0;
  logic [65:0]   v_in = '0;
  logic          last_in = 1'b0;
  logic          ready_out;
  logic          fb_push;
  logic [RW-1:0] fb_row;
  logic [65:0]   fb_v;
  logic          add_push, done_push;
  logic [RW-1:0] add_row, done_row;
  logic [65:0]   add_v0, add_v1, done_v;

  pair_scheduler #(.ROW_WIDTH(RW), .NUM_CTX(NC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .push_in(push_in), .row_in(row_in), .v_in(v_in),
    .last_in(last_in), .ready_out(ready_out), .fb_push(fb_push), .fb_row(fb_row),
    .fb_v(fb_v), .add_push(add_push), .add_row(add_row), .add_v0(add_v0),
    .add_v1(add_v1), .done_push(done_push), .done_row(done_row), .done_v(done_v)
  );

  always #5 clk = ~clk;

  // Adder model: result = v0 + v1 (mod 2^66) returned lat cycles after add_push.
  logic          model_en = 1'b0;
  int            lat = 11;
  logic          fb_man = 1'b0;
  logic [RW-1:0] fb_man_row = '0;
  logic [65:0]   fb_man_v = '0;
  logic          pv [16];
  logic [RW-1:0] prow [16];
  logic [65:0]   psum [16];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        pv[k] <= 1'b0; prow[k] <= '0; psum[k] <= '0;
      end
    end else begin
      pv[0] <= add_push; prow[0] <= add_row; psum[0] <= add_v0 + add_v1;
      for (int k = 1; k < 16; k++) begin
        pv[k] <= pv[k-1]; prow[k] <= prow[k-1]; psum[k] <= psum[k-1];
      end
    end
  end

  assign fb_push = model_en ? pv[lat-1]   : fb_man;
  assign fb_row  = model_en ? prow[lat-1] : fb_man_row;
  assign fb_v    = model_en ? psum[lat-1] : fb_man_v;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [RW-1:0] r, input logic [65:0] v,
                       input logic l, input logic fp, input logic [RW-1:0] fr,
                       input logic [65:0] fv);
    @(posedge clk); #1;
    push_in = p; row_in = r; v_in = v; last_in = l;
    fb_man = fp; fb_man_row = fr; fb_man_v = fv;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; push_in = 1'b0; fb_man = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic p; logic [RW-1:0] r; logic [65:0] v; logic l;
    logic fp; logic [RW-1:0] fr; logic [65:0] fv;
    logic e_rdy; logic e_add; logic [RW-1:0] e_arow; logic [65:0] e_a0; logic [65:0] e_a1;
    logic e_done; logic [RW-1:0] e_drow; logic [65:0] e_dv;
  } vec_t;
  vec_t vecs[$];

  task automatic addv(input logic p, input logic [RW-1:0] r, input logic [65:0] v, input logic l,
                      input logic fp, input logic [RW-1:0] fr, input logic [65:0] fv,
                      input logic er, input logic ea, input logic [RW-1:0] ear,
                      input logic [65:0] ea0, input logic [65:0] ea1,
                      input logic ed, input logic [RW-1:0] edr, input logic [65:0] edv);
    vecs.push_back('{p, r, v, l, fp, fr, fv, er, ea, ear, ea0, ea1, ed, edr, edv});
  endtask

  localparam logic [65:0] VA = 66'h2_0000_0000_0000_00A5;
  localparam logic [65:0] VB = 66'h1_8000_0000_0000_0B0B;
  localparam logic [65:0] VC = 66'h0_1234_5678_9ABC_DEF0;
  localparam logic [65:0] VD = 66'h3_FFFF_0000_1111_2222;
  localparam logic [65:0] VE = 66'h0_0000_0000_0000_0E0E;
  localparam logic [65:0] VF = 66'h2_AAAA_5555_AAAA_5555;
  localparam logic [65:0] VG = 66'h1_0000_0000_0000_0007;
  localparam logic [65:0] P1 = 66'h0_0000_0000_0000_1001;
  localparam logic [65:0] P2 = 66'h0_0000_0000_0000_2002;
  localparam logic [65:0] X0 = 66'h0_0000_0000_0000_3003;
  localparam logic [65:0] X1 = 66'h0_0000_0000_0000_4004;
  localparam logic [65:0] VX = 66'h3_0000_0000_0000_5005;
  localparam logic [65:0] VY = 66'h1_0000_0000_0000_6006;
  localparam logic [65:0] VZ = 66'h2_0000_0000_0000_7007;
  localparam logic [65:0] F1 = 66'h0_0000_0000_0000_8008;

  // Random-phase state
  int unsigned   act_row[$];
  int            act_rem[$];
  logic [65:0]   act_sum[$];
  logic [RW+65:0] exp_q[$];
  logic [RW-1:0] next_row;
  logic [95:0]   r96;
  logic [65:0]   s_exp;
  int prods, rows, adds, pend_j, fbc, dnc, cyc;
  logic pending, found, gen;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready_out, 1'b1);
    chk("rst_add_push", add_push, 1'b0);
    chk("rst_done_push", done_push, 1'b0);
    chk("rst_add_v0", add_v0, '0);
    chk("rst_done_v", done_v, '0);

    // Directed vector table; outputs in step k reflect the edge ending step k-1.
    addv(1, 5, VA, 1, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0,     0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0,     1, 5, VA);
    addv(0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0,     0, 0, 0);
    addv(1, 7, P1, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
    addv(1, 7, P2, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
    addv(1, 7, VC, 0, 1, 7, VD,  1, 1, 7, P1, P2,   0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,    1, 1, 7, VD, VC,   0, 0, 0);
    addv(0, 0, 0, 0, 1, 7, VE,   1, 0, 0, 0, 0,     0, 0, 0);
    addv(1, 7, VF, 1, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
    addv(0, 0, 0, 0, 1, 7, VG,   1, 1, 7, VE, VF,   0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0,     0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0,     1, 7, VG);
    addv(1, 1, X0, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
    addv(1, 1, X1, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
    addv(1, 1, VX, 0, 0, 0, 0,   1, 1, 1, X0, X1,   0, 0, 0);
    addv(1, 2, VY, 0, 0, 0, 0,   1, 0, 0, 0, 0,     0, 0, 0);
    addv(1, 2, VZ, 0, 1, 1, F1,  0, 0, 0, 0, 0,     0, 0, 0);
    addv(1, 2, VZ, 0, 0, 0, 0,   1, 1, 1, VX, F1,   0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,    1, 1, 2, VY, VZ,   0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0,     0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].p, vecs[k].r, vecs[k].v, vecs[k].l, vecs[k].fp, vecs[k].fr, vecs[k].fv);
      chk($sformatf("vec%0d_ready", k), ready_out, vecs[k].e_rdy);
      chk($sformatf("vec%0d_add_push", k), add_push, vecs[k].e_add);
      if (vecs[k].e_add) begin
        chk($sformatf("vec%0d_add_row", k), add_row, vecs[k].e_arow);
        chk($sformatf("vec%0d_add_v0", k), add_v0, vecs[k].e_a0);
        chk($sformatf("vec%0d_add_v1", k), add_v1, vecs[k].e_a1);
      end
      chk($sformatf("vec%0d_done_push", k), done_push, vecs[k].e_done);
      if (vecs[k].e_done) begin
        chk($sformatf("vec%0d_done_row", k), done_row, vecs[k].e_drow);
        chk($sformatf("vec%0d_done_v", k), done_v, vecs[k].e_dv);
      end
    end

    // Two-product row through the adder model with latency 11
    model_en = 1'b1; lat = 11;
    do_reset();
    drive(1, 3, VA, 0, 0, 0, 0);
    drive(1, 3, VB, 1, 0, 0, 0);
    idle();
    chk("two_add_push", add_push, 1'b1);
    chk("two_add_row", add_row, 66'd3);
    chk("two_add_v0", add_v0, VA);
    chk("two_add_v1", add_v1, VB);
    s_exp = VA + VB;
    fbc = -1; dnc = -1;
    for (int k = 1; k < 40 && dnc < 0; k++) begin
      idle();
      if (fb_push && fbc < 0) fbc = k;
      if (done_push) begin
        dnc = k;
        chk("two_done_row", done_row, 66'd3);
        chk("two_done_v", done_v, s_exp);
      end
    end
    chk("two_done_seen", (dnc >= 0 && fbc >= 0), 1'b1);
    chk("two_done_gap", dnc - fbc, 66'd2);

    // All contexts busy: a fifth row waits until one retires
    model_en = 1'b0;
    do_reset();
    drive(1, 10, VA, 0, 0, 0, 0);
    drive(1, 11, VB, 0, 0, 0, 0);
    drive(1, 12, VC, 0, 0, 0, 0);
    drive(1, 13, VD, 0, 0, 0, 0);
    drive(1, 13, VE, 1, 0, 0, 0);
    drive(1, 14, VF, 1, 0, 0, 0);
    chk("full_ready0_a", ready_out, 1'b0);
    chk("full_add_push", add_push, 1'b1);
    chk("full_add_v0", add_v0, VD);
    drive(1, 14, VF, 1, 0, 0, 0);
    chk("full_ready0_b", ready_out, 1'b0);
    drive(1, 14, VF, 1, 1, 13, VG);
    chk("full_ready0_fb", ready_out, 1'b0);
    drive(1, 14, VF, 1, 0, 0, 0);
    chk("full_ready0_cmp", ready_out, 1'b0);
    chk("full_done0", done_push, 1'b0);
    drive(1, 14, VF, 1, 0, 0, 0);
    chk("full_ready1", ready_out, 1'b1);
    chk("full_done_push", done_push, 1'b1);
    chk("full_done_row", done_row, 66'd13);
    chk("full_done_v", done_v, VG);
    idle();

    // Reset with several contexts open, then a fresh single-product row
    @(posedge clk); #1;
    rst = 1'b1; push_in = 1'b0;
    @(negedge clk);
    chk("mrst_ready_in_rst", ready_out, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready", ready_out, 1'b1);
    chk("mrst_add_push", add_push, 1'b0);
    chk("mrst_add_row", add_row, '0);
    chk("mrst_add_v0", add_v0, '0);
    chk("mrst_add_v1", add_v1, '0);
    chk("mrst_done_push", done_push, 1'b0);
    chk("mrst_done_row", done_row, '0);
    chk("mrst_done_v", done_v, '0);
    drive(1, 9, VC, 1, 0, 0, 0);
    idle();
    chk("mrst_single_no_add", add_push, 1'b0);
    chk("mrst_single_wait", done_push, 1'b0);
    idle();
    chk("mrst_single_done", done_push, 1'b1);
    chk("mrst_single_row", done_row, 66'd9);
    chk("mrst_single_v", done_v, VC);

    // Random rows: each row's final sum equals the modular sum of its products
    model_en = 1'b1; lat = $urandom_range(1, 11);
    do_reset();
    prods = 0; rows = 0; adds = 0; pending = 1'b0; pend_j = 0;
    next_row = 10'd100;
    cyc = 0;
    while (cyc < 20000) begin
      gen = (cyc < 3000);
      if (!gen && !pending && act_row.size() == 0 && exp_q.size() == 0) break;
      @(posedge clk); #1;
      if (!pending) begin
        push_in = 1'b0; last_in = 1'b0;
        if ($urandom_range(0, 9) < 7) begin
          if (gen && (act_row.size() + exp_q.size() < NC) &&
              ($urandom_range(0, 2) == 0 || act_row.size() == 0)) begin
            act_row.push_back(int'(next_row));
            act_rem.push_back($urandom_range(1, 6));
            act_sum.push_back('0);
            next_row = next_row + 1'b1;
            rows++;
          end
          if (act_row.size() > 0) begin
            pend_j = $urandom_range(0, act_row.size() - 1);
            r96 = {$urandom, $urandom, $urandom};
            row_in = RW'(act_row[pend_j]);
            v_in = r96[65:0];
            last_in = (act_rem[pend_j] == 1);
            push_in = 1'b1;
            pending = 1'b1;
          end
        end
      end
      @(negedge clk);
      if (push_in && ready_out) begin
        act_sum[pend_j] = act_sum[pend_j] + v_in;
        act_rem[pend_j] = act_rem[pend_j] - 1;
        prods++;
        if (act_rem[pend_j] == 0) begin
          exp_q.push_back({RW'(act_row[pend_j]), act_sum[pend_j]});
          act_row.delete(pend_j); act_rem.delete(pend_j); act_sum.delete(pend_j);
        end
        pending = 1'b0;
      end
      if (add_push) adds++;
      if (done_push) begin
        found = 1'b0;
        for (int q = 0; q < exp_q.size(); q++) begin
          if (!found && exp_q[q][RW+65:66] == done_row) begin
            found = 1'b1;
            chk("rand_done_v", done_v, exp_q[q][65:0]);
            exp_q.delete(q);
          end
        end
        chk("rand_done_row_known", found, 1'b1);
      end
      cyc++;
    end
    push_in = 1'b0;
    chk("rand_drained", act_row.size() + exp_q.size(), '0);
    chk("rand_issue_count", adds, prods - rows);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pair_scheduler.md
PAIR_SCHEDULER -- requirements
Module: pair_scheduler

Interface
REQ-001 Parameter ROW_WIDTH, default 10, row-tag width, matching the adder pipe's row tag.
REQ-002 Parameter NUM_CTX, default 4, number of concurrently open row contexts.
REQ-003 Parameter CNT_WIDTH, default 5, width of each context's in-flight counter; must cover adder latency + 1.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 push_in  in  1  product valid from the multiplier stage.
REQ-007 row_in  in  ROW_WIDTH  row tag of the product.
REQ-008 v_in  in  66  FloPoCo double product value.
REQ-009 last_in  in  1  product is the final one of its row.
REQ-010 ready_out  out  1  combinational; the product is accepted when push_in & ready_out.
REQ-011 fb_push  in  1  adder result valid, fed back from the adder pipe output; never stalled.
REQ-012 fb_row  in  ROW_WIDTH  row tag of the adder result.
REQ-013 fb_v  in  66  adder result value.
REQ-014 add_push  out  1  registered; issue a pair to the adder pipe.
REQ-015 add_row  out  ROW_WIDTH  registered row tag of the issued pair.
REQ-016 add_v0, add_v1  out  66 each  registered operands.
REQ-017 done_push  out  1  registered; a row's final sum is valid.
REQ-018 done_row  out  ROW_WIDTH  registered row tag of the final sum.
REQ-019 done_v  out  66  registered final sum.

Function
REQ-020 Each context SHALL hold: valid, row, hold_valid, hold_v (66), last_seen and inflight (CNT_WIDTH).
REQ-021 A product whose row_in matches a valid context SHALL use that context; otherwise it SHALL allocate the lowest-index invalid context, with inflight=0 and hold_valid=0.
REQ-022 Values SHALL pass through unmodified; the block does no arithmetic.
REQ-023 Arriving value, context hold empty: value becomes the hold value.
REQ-024 Arriving value, context hold full: issue (add_v0=hold_v, add_v1=value) next cycle, clear hold and increment inflight.
REQ-025 Feedback SHALL decrement its context's inflight in the same cycle it is processed.
REQ-026 Feedback and product in the same cycle for the same context with hold empty: issue (add_v0=fb_v, add_v1=v_in); inflight stays unchanged.
REQ-027 Feedback and product in the same cycle for the same context with hold full: issue (hold_v, fb_v); v_in becomes the hold value; inflight stays unchanged.
REQ-028 At most one adder issue per cycle. ready_out SHALL be 0 when:
- the feedback and the product target different contexts and both would issue; or
- the product needs a context and none is free; or
- rst=1.
REQ-029 Whenever fb_push=1, fb_row SHALL already match a valid context; any other case is illegal stimulus and undefined.
REQ-030 On an accepted product with last_in=1, the context SHALL set last_seen.
REQ-031 Completion: a context is complete when, in its registered state, valid, last_seen, inflight==0 and hold_valid are all true, and no product or feedback targets it this cycle.
REQ-032 On completion the block SHALL register done_push=1, done_row=row and done_v=hold_v next cycle, and invalidate the context.
REQ-033 When several contexts are complete, the lowest index SHALL be retired; the others wait. At most one done_push per cycle.
REQ-034 A single-product row (last_in on its first product) SHALL produce done_push 2 cycles after acceptance, with no adder issue.
REQ-035 A freed context SHALL be reusable by the same or another row in the cycle after retirement.
REQ-036 add_push and done_push SHALL be 0 in any cycle without a corresponding event.

Reset
REQ-037 While rst=1 on a clock edge, all contexts SHALL become invalid and all counters and flags 0, and add_push, add_row, add_v0, add_v1, done_push, done_row and done_v SHALL all register 0.
REQ-038 Reset mid-operation SHALL discard held values and in-flight accounting; results returned later are illegal stimulus.

Verification
REQ-039 Single-product row: row 5, value A, last_in=1 -> no add_push; done_push with row 5, value A 2 cycles later.
REQ-040 Two-product row 3 (A, then B with last), adder model latency 11 -> add_push(3,A,B) the cycle after B; sum S fed back; done(3,S) 2 cycles after the feedback.
REQ-041 Product C for row 7, hold empty, arriving the same cycle as feedback D for row 7 -> add_push(7,D,C); inflight unchanged.
REQ-042 Conflict: row 1 holds X and row 2 holds Y; feedback for row 1 and product for row 2 arrive together -> ready_out=0; the feedback issues (X, fb); the product is accepted the next cycle.
REQ-043 NUM_CTX=4 rows open and a fifth row's product arrives -> ready_out=0 until a context retires, then the product is accepted.
REQ-044 Assert rst mid-stream with 3 contexts open -> next cycle all outputs 0 and ready_out=1; a fresh single-product row then completes normally.
